// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg : shared constants, FSM encoding and GF(2^8) helpers for AES-128
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam int         NUM_ROUNDS = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
// aes_sbox : combinational FIPS-197 forward S-box, one byte in, one byte out
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  always_comb begin
    out_o = 8'h00;
    case (in_i)
      8'h00: out_o = 8'h63; 8'h01: out_o = 8'h7c; 8'h02: out_o = 8'h77; 8'h03: out_o = 8'h7b;
      8'h04: out_o = 8'hf2; 8'h05: out_o = 8'h6b; 8'h06: out_o = 8'h6f; 8'h07: out_o = 8'hc5;
      8'h08: out_o = 8'h30; 8'h09: out_o = 8'h01; 8'h0a: out_o = 8'h67; 8'h0b: out_o = 8'h2b;
      8'h0c: out_o = 8'hfe; 8'h0d: out_o = 8'hd7; 8'h0e: out_o = 8'hab; 8'h0f: out_o = 8'h76;
      8'h10: out_o = 8'hca; 8'h11: out_o = 8'h82; 8'h12: out_o = 8'hc9; 8'h13: out_o = 8'h7d;
      8'h14: out_o = 8'hfa; 8'h15: out_o = 8'h59; 8'h16: out_o = 8'h47; 8'h17: out_o = 8'hf0;
      8'h18: out_o = 8'had; 8'h19: out_o = 8'hd4; 8'h1a: out_o = 8'ha2; 8'h1b: out_o = 8'haf;
      8'h1c: out_o = 8'h9c; 8'h1d: out_o = 8'ha4; 8'h1e: out_o = 8'h72; 8'h1f: out_o = 8'hc0;
      8'h20: out_o = 8'hb7; 8'h21: out_o = 8'hfd; 8'h22: out_o = 8'h93; 8'h23: out_o = 8'h26;
      8'h24: out_o = 8'h36; 8'h25: out_o = 8'h3f; 8'h26: out_o = 8'hf7; 8'h27: out_o = 8'hcc;
      8'h28: out_o = 8'h34; 8'h29: out_o = 8'ha5; 8'h2a: out_o = 8'he5; 8'h2b: out_o = 8'hf1;
      8'h2c: out_o = 8'h71; 8'h2d: out_o = 8'hd8; 8'h2e: out_o = 8'h31; 8'h2f: out_o = 8'h15;
      8'h30: out_o = 8'h04; 8'h31: out_o = 8'hc7; 8'h32: out_o = 8'h23; 8'h33: out_o = 8'hc3;
      8'h34: out_o = 8'h18; 8'h35: out_o = 8'h96; 8'h36: out_o = 8'h05; 8'h37: out_o = 8'h9a;
      8'h38: out_o = 8'h07; 8'h39: out_o = 8'h12; 8'h3a: out_o = 8'h80; 8'h3b: out_o = 8'he2;
      8'h3c: out_o = 8'heb; 8'h3d: out_o = 8'h27; 8'h3e: out_o = 8'hb2; 8'h3f: out_o = 8'h75;
      8'h40: out_o = 8'h09; 8'h41: out_o = 8'h83; 8'h42: out_o = 8'h2c; 8'h43: out_o = 8'h1a;
      8'h44: out_o = 8'h1b; 8'h45: out_o = 8'h6e; 8'h46: out_o = 8'h5a; 8'h47: out_o = 8'ha0;
      8'h48: out_o = 8'h52; 8'h49: out_o = 8'h3b; 8'h4a: out_o = 8'hd6; 8'h4b: out_o = 8'hb3;
      8'h4c: out_o = 8'h29; 8'h4d: out_o = 8'he3; 8'h4e: out_o = 8'h2f; 8'h4f: out_o = 8'h84;
      8'h50: out_o = 8'h53; 8'h51: out_o = 8'hd1; 8'h52: out_o = 8'h00; 8'h53: out_o = 8'hed;
      8'h54: out_o = 8'h20; 8'h55: out_o = 8'hfc; 8'h56: out_o = 8'hb1; 8'h57: out_o = 8'h5b;
      8'h58: out_o = 8'h6a; 8'h59: out_o = 8'hcb; 8'h5a: out_o = 8'hbe; 8'h5b: out_o = 8'h39;
      8'h5c: out_o = 8'h4a; 8'h5d: out_o = 8'h4c; 8'h5e: out_o = 8'h58; 8'h5f: out_o = 8'hcf;
      8'h60: out_o = 8'hd0; 8'h61: out_o = 8'hef; 8'h62: out_o = 8'haa; 8'h63: out_o = 8'hfb;
      8'h64: out_o = 8'h43; 8'h65: out_o = 8'h4d; 8'h66: out_o = 8'h33; 8'h67: out_o = 8'h85;
      8'h68: out_o = 8'h45; 8'h69: out_o = 8'hf9; 8'h6a: out_o = 8'h02; 8'h6b: out_o = 8'h7f;
      8'h6c: out_o = 8'h50; 8'h6d: out_o = 8'h3c; 8'h6e: out_o = 8'h9f; 8'h6f: out_o = 8'ha8;
      8'h70: out_o = 8'h51; 8'h71: out_o = 8'ha3; 8'h72: out_o = 8'h40; 8'h73: out_o = 8'h8f;
      8'h74: out_o = 8'h92; 8'h75: out_o = 8'h9d; 8'h76: out_o = 8'h38; 8'h77: out_o = 8'hf5;
      8'h78: out_o = 8'hbc; 8'h79: out_o = 8'hb6; 8'h7a: out_o = 8'hda; 8'h7b: out_o = 8'h21;
      8'h7c: out_o = 8'h10; 8'h7d: out_o = 8'hff; 8'h7e: out_o = 8'hf3; 8'h7f: out_o = 8'hd2;
      8'h80: out_o = 8'hcd; 8'h81: out_o = 8'h0c; 8'h82: out_o = 8'h13; 8'h83: out_o = 8'hec;
      8'h84: out_o = 8'h5f; 8'h85: out_o = 8'h97; 8'h86: out_o = 8'h44; 8'h87: out_o = 8'h17;
      8'h88: out_o = 8'hc4; 8'h89: out_o = 8'ha7; 8'h8a: out_o = 8'h7e; 8'h8b: out_o = 8'h3d;
      8'h8c: out_o = 8'h64; 8'h8d: out_o = 8'h5d; 8'h8e: out_o = 8'h19; 8'h8f: out_o = 8'h73;
      8'h90: out_o = 8'h60; 8'h91: out_o = 8'h81; 8'h92: out_o = 8'h4f; 8'h93: out_o = 8'hdc;
      8'h94: out_o = 8'h22; 8'h95: out_o = 8'h2a; 8'h96: out_o = 8'h90; 8'h97: out_o = 8'h88;
      8'h98: out_o = 8'h46; 8'h99: out_o = 8'hee; 8'h9a: out_o = 8'hb8; 8'h9b: out_o = 8'h14;
      8'h9c: out_o = 8'hde; 8'h9d: out_o = 8'h5e; 8'h9e: out_o = 8'h0b; 8'h9f: out_o = 8'hdb;
      8'ha0: out_o = 8'he0; 8'ha1: out_o = 8'h32; 8'ha2: out_o = 8'h3a; 8'ha3: out_o = 8'h0a;
      8'ha4: out_o = 8'h49; 8'ha5: out_o = 8'h06; 8'ha6: out_o = 8'h24; 8'ha7: out_o = 8'h5c;
      8'ha8: out_o = 8'hc2; 8'ha9: out_o = 8'hd3; 8'haa: out_o = 8'hac; 8'hab: out_o = 8'h62;
      8'hac: out_o = 8'h91; 8'had: out_o = 8'h95; 8'hae: out_o = 8'he4; 8'haf: out_o = 8'h79;
      8'hb0: out_o = 8'he7; 8'hb1: out_o = 8'hc8; 8'hb2: out_o = 8'h37; 8'hb3: out_o = 8'h6d;
      8'hb4: out_o = 8'h8d; 8'hb5: out_o = 8'hd5; 8'hb6: out_o = 8'h4e; 8'hb7: out_o = 8'ha9;
      8'hb8: out_o = 8'h6c; 8'hb9: out_o = 8'h56; 8'hba: out_o = 8'hf4; 8'hbb: out_o = 8'hea;
      8'hbc: out_o = 8'h65; 8'hbd: out_o = 8'h7a; 8'hbe: out_o = 8'hae; 8'hbf: out_o = 8'h08;
      8'hc0: out_o = 8'hba; 8'hc1: out_o = 8'h78; 8'hc2: out_o = 8'h25; 8'hc3: out_o = 8'h2e;
      8'hc4: out_o = 8'h1c; 8'hc5: out_o = 8'ha6; 8'hc6: out_o = 8'hb4; 8'hc7: out_o = 8'hc6;
      8'hc8: out_o = 8'he8; 8'hc9: out_o = 8'hdd; 8'hca: out_o = 8'h74; 8'hcb: out_o = 8'h1f;
      8'hcc: out_o = 8'h4b; 8'hcd: out_o = 8'hbd; 8'hce: out_o = 8'h8b; 8'hcf: out_o = 8'h8a;
      8'hd0: out_o = 8'h70; 8'hd1: out_o = 8'h3e; 8'hd2: out_o = 8'hb5; 8'hd3: out_o = 8'h66;
      8'hd4: out_o = 8'h48; 8'hd5: out_o = 8'h03; 8'hd6: out_o = 8'hf6; 8'hd7: out_o = 8'h0e;
      8'hd8: out_o = 8'h61; 8'hd9: out_o = 8'h35; 8'hda: out_o = 8'h57; 8'hdb: out_o = 8'hb9;
      8'hdc: out_o = 8'h86; 8'hdd: out_o = 8'hc1; 8'hde: out_o = 8'h1d; 8'hdf: out_o = 8'h9e;
      8'he0: out_o = 8'he1; 8'he1: out_o = 8'hf8; 8'he2: out_o = 8'h98; 8'he3: out_o = 8'h11;
      8'he4: out_o = 8'h69; 8'he5: out_o = 8'hd9; 8'he6: out_o = 8'h8e; 8'he7: out_o = 8'h94;
      8'he8: out_o = 8'h9b; 8'he9: out_o = 8'h1e; 8'hea: out_o = 8'h87; 8'heb: out_o = 8'he9;
      8'hec: out_o = 8'hce; 8'hed: out_o = 8'h55; 8'hee: out_o = 8'h28; 8'hef: out_o = 8'hdf;
      8'hf0: out_o = 8'h8c; 8'hf1: out_o = 8'ha1; 8'hf2: out_o = 8'h89; 8'hf3: out_o = 8'h0d;
      8'hf4: out_o = 8'hbf; 8'hf5: out_o = 8'he6; 8'hf6: out_o = 8'h42; 8'hf7: out_o = 8'h68;
      8'hf8: out_o = 8'h41; 8'hf9: out_o = 8'h99; 8'hfa: out_o = 8'h2d; 8'hfb: out_o = 8'h0f;
      8'hfc: out_o = 8'hb0; 8'hfd: out_o = 8'h54; 8'hfe: out_o = 8'hbb; 8'hff: out_o = 8'h16;
      default: out_o = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/aes_key_schedule_gen.sv
// ============================================================================
// aes_key_schedule_gen : iterative AES-128 key expansion, one round key per clk,
//                        then a one-cycle start pulse to the round transformer
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_key_schedule_gen
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_,
  input  logic [127:0] key_in,
  input  logic         engine_start,
  input  logic         transformer_done,
  output logic         transformer_start,
  output logic [127:0] round0_key,
  output logic [127:0] round1_key,
  output logic [127:0] round2_key,
  output logic [127:0] round3_key,
  output logic [127:0] round4_key,
  output logic [127:0] round5_key,
  output logic [127:0] round6_key,
  output logic [127:0] round7_key,
  output logic [127:0] round8_key,
  output logic [127:0] round9_key,
  output logic [127:0] round10_key
);

  logic [1:0]   state_q, state_d;
  logic [3:0]   count_q, count_d;
  logic [7:0]   rcon_q,  rcon_d;
  logic         start_q, start_d;
  logic [127:0] rk_q [0:NUM_ROUNDS];

  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;

  // The round being written is count_q; its input is the key one slot below.
  always_comb begin
    prev_key = rk_q[0];
    for (int i = 1; i <= NUM_ROUNDS; i++) begin
      if (count_q == 4'(i)) prev_key = rk_q[i-1];
    end
  end

  assign rot_w3 = {prev_key[23:0], prev_key[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_w3[8*j +: 8]),
      .out_o (sub_w3[8*j +: 8])
    );
  end

  assign t_word   = sub_w3 ^ {rcon_q, 24'h000000};
  assign n0       = prev_key[127:96] ^ t_word;
  assign n1       = prev_key[95:64]  ^ n0;
  assign n2       = prev_key[63:32]  ^ n1;
  assign n3       = prev_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rcon_d  = rcon_q;
    start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (engine_start) begin
          state_d = ST_EXPAND;
          count_d = 4'd1;
          rcon_d  = RCON_INIT;
        end
      end
      ST_EXPAND: begin
        count_d = count_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        if (count_q == 4'(NUM_ROUNDS)) begin
          state_d = ST_WAIT;
          start_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (transformer_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= ST_IDLE;
      count_q <= 4'd0;
      rcon_q  <= RCON_INIT;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rcon_q  <= rcon_d;
      start_q <= start_d;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= 128'h0;
    end else begin
      if (state_q == ST_IDLE && engine_start) rk_q[0] <= key_in;
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
        if (state_q == ST_EXPAND && count_q == 4'(i)) rk_q[i] <= next_key;
      end
    end
  end

  assign transformer_start = start_q;
  assign round0_key        = rk_q[0];
  assign round1_key        = rk_q[1];
  assign round2_key        = rk_q[2];
  assign round3_key        = rk_q[3];
  assign round4_key        = rk_q[4];
  assign round5_key        = rk_q[5];
  assign round6_key        = rk_q[6];
  assign round7_key        = rk_q[7];
  assign round8_key        = rk_q[8];
  assign round9_key        = rk_q[9];
  assign round10_key       = rk_q[10];

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule_gen.sv
// ============================================================================
// tb_aes_key_schedule_gen : known-answer vectors, random keys against a
//                           GF(2^8)-derived key-expansion model, corner cases
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_key_schedule_gen;

  logic         clk = 1'b0;
  logic         rst_;
  logic [127:0] key_in;
  logic         engine_start;
  logic         transformer_done;
  logic         transformer_start;
  logic [127:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10;
  logic [127:0] dut_rk [0:10];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] exp_r1;
    logic [127:0] exp_r10;
  } vec_t;

  vec_t vecs [0:1];

  logic [7:0]   sbox_m   [0:255];
  logic [127:0] model_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_schedule_gen dut (
    .clk               (clk),
    .rst_              (rst_),
    .key_in            (key_in),
    .engine_start      (engine_start),
    .transformer_done  (transformer_done),
    .transformer_start (transformer_start),
    .round0_key        (r0),
    .round1_key        (r1),
    .round2_key        (r2),
    .round3_key        (r3),
    .round4_key        (r4),
    .round5_key        (r5),
    .round6_key        (r6),
    .round7_key        (r7),
    .round8_key        (r8),
    .round9_key        (r9),
    .round10_key       (r10)
  );

  always #5 clk = ~clk;

  always_comb begin
    dut_rk[0] = r0;  dut_rk[1] = r1;  dut_rk[2] = r2;  dut_rk[3] = r3;
    dut_rk[4] = r4;  dut_rk[5] = r5;  dut_rk[6] = r6;  dut_rk[7] = r7;
    dut_rk[8] = r8;  dut_rk[9] = r9;  dut_rk[10] = r10;
  end

  // ---------------- reference model: S-box from GF inverse + affine map -----
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      if (x == 0) inv = 8'h00;
      else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking helpers ----------------------------------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_model(input string tag);
    for (int r = 0; r <= 10; r++) check($sformatf("%s rk%0d", tag, r), dut_rk[r], model_rk[r]);
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r <= 10; r++) check($sformatf("%s rk%0d zero", tag, r), dut_rk[r], 128'h0);
    check({tag, " start zero"}, {127'h0, transformer_start}, 128'h0);
  endtask

  task automatic start_key(input logic [127:0] k);
    @(negedge clk); key_in = k; engine_start = 1'b1;
    @(negedge clk); engine_start = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); transformer_done = 1'b1;
    @(negedge clk); transformer_done = 1'b0;
  endtask

  // Runs a full expansion; checks the start pulse every cycle and optionally table values.
  task automatic run_and_check(input logic [127:0] k, input logic [127:0] e1,
                               input logic [127:0] e10, input bit chk_table, input string tag);
    model_expand(k);
    start_key(k);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      check($sformatf("%s start@E%0d", tag, i), {127'h0, transformer_start}, {127'h0, 1'(i == 10)});
      if (chk_table && i == 1)  check({tag, " r1"},  r1,  e1);
      if (chk_table && i == 10) check({tag, " r10"}, r10, e10);
    end
    check_all_model(tag);
  endtask

  initial begin
    logic [127:0] k1, k2;

    vecs[0] = '{key: FIPS_KEY,
                exp_r1:  128'ha0fafe1788542cb123a339392a6c7605,
                exp_r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{key: 128'h0,
                exp_r1:  128'h62636363626363636263636362636363,
                exp_r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst_ = 1'b1; key_in = 128'h0; engine_start = 1'b0; transformer_done = 1'b0;
    build_sbox();
    #12;
    check_all_zero("por");
    @(negedge clk); rst_ = 1'b0;

    // Known-answer vectors
    for (int v = 0; v < 2; v++) begin
      run_and_check(vecs[v].key, vecs[v].exp_r1, vecs[v].exp_r10, 1'b1, $sformatf("kat%0d", v));
      pulse_done();
    end

    // Random keys against the model
    for (int n = 0; n < 3; n++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      run_and_check(k1, 128'h0, 128'h0, 1'b0, $sformatf("rnd%0d", n));
      pulse_done();
    end

    // Busy protection: start/key changes during EXPAND and WAIT are ignored
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    model_expand(k1);
    start_key(k1);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      check($sformatf("busy start@E%0d", i), {127'h0, transformer_start}, {127'h0, 1'(i == 10)});
      if (i == 4) begin key_in = k2; engine_start = 1'b1; end
      if (i == 6) engine_start = 1'b0;
    end
    key_in = k2; engine_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("wait start %0d", i), {127'h0, transformer_start}, 128'h0);
    end
    transformer_done = 1'b1;
    @(negedge clk);
    transformer_done = 1'b0; engine_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("idle start %0d", i), {127'h0, transformer_start}, 128'h0);
    end
    check_all_model("busy hold");
    run_and_check(k2, 128'h0, 128'h0, 1'b0, "busy new");
    pulse_done();

    // Reset mid-expansion, asynchronously between edges
    start_key(FIPS_KEY);
    repeat (5) @(negedge clk);
    #2 rst_ = 1'b1;
    #1 check_all_zero("mid rst");
    #1 rst_ = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("post rst start %0d", i), {127'h0, transformer_start}, 128'h0);
    end
    check("post rst r5", r5, 128'h0);
    run_and_check(vecs[0].key, vecs[0].exp_r1, vecs[0].exp_r10, 1'b1, "after rst");
    pulse_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
